// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter for the 7-segment clock datapath. It keeps
// the count as packed BCD digits for the segment decoders and as a binary
// mirror for comparators and alarms. The two forms update on the same edge
// and always hold the same value.
//
// carry_o and borrow_o are combinational, so stages can be chained
// (seconds -> minutes -> hours) and still advance within a single cycle.
//
// Optional feature, selected by the macro BCD_COUNTER_SATURATE_EN:
//   defined   : an increment at MAX_COUNT holds at MAX_COUNT, and a decrement
//               at 0 holds at 0. carry_o/borrow_o still flag the limit hit.
//   undefined : the count wraps MAX_COUNT -> 0 and 0 -> MAX_COUNT.
//
// Parameters:
//   NUM_DIGITS   number of BCD digits (1..6)
//   MAX_COUNT    terminal decimal value (1 .. 10^NUM_DIGITS-1)
//   RESET_VALUE  value loaded by rst_ni and clear_i (0 .. MAX_COUNT)
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   clear_i        synchronous return to RESET_VALUE (highest priority)
//   load_i         synchronous load of load_digits_i
//   load_digits_i  packed BCD load value; the ones digit is in bits [3:0]
//   inc_i, dec_i   count up / down by one (both high = hold)
//   digits_o       current count, packed BCD
//   count_o        current count, binary
//   carry_o        this cycle's increment is at MAX_COUNT
//   borrow_o       this cycle's decrement is at 0
//   load_err_o     one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int NUM_DIGITS  = 2,
  parameter int MAX_COUNT   = 99,
  parameter int RESET_VALUE = 0,
  localparam int BIN_W      = $clog2(MAX_COUNT + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_digits_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [BIN_W-1:0]        count_o,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic                    load_err_o
);

  localparam int DW = 4 * NUM_DIGITS;

  // Elaboration-time decimal -> packed BCD conversion for the constants.
  function automatic logic [DW-1:0] to_bcd(input int value);
    logic [DW-1:0] res;
    int            v;
    res = '0;
    v   = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v             = v / 10;
    end
    return res;
  endfunction

  localparam logic [DW-1:0]    MAX_BCD   = to_bcd(MAX_COUNT);
  localparam logic [DW-1:0]    RESET_BCD = to_bcd(RESET_VALUE);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_COUNT);
  localparam logic [BIN_W-1:0] RESET_BIN = BIN_W'(RESET_VALUE);
  localparam logic [BIN_W-1:0] ONE_BIN   = BIN_W'(1);

  logic [DW-1:0]    digits_q, digits_d;
  logic [BIN_W-1:0] count_q, count_d;
  logic             load_err_q, load_err_d;

  logic             at_max, at_zero;
  logic             do_inc, do_dec;
  logic [DW-1:0]    inc_digits, dec_digits;
  logic [31:0]      load_val;
  logic             load_digits_ok;
  logic             load_ok;

  // The binary mirror is narrower than the digits, so the boundary tests use it.
  assign at_max  = (count_q == MAX_BIN);
  assign at_zero = (count_q == '0);

  // An increment or decrement only happens when neither clear nor load wins
  // and exactly one direction is requested.
  assign do_inc = inc_i & ~dec_i & ~clear_i & ~load_i;
  assign do_dec = dec_i & ~inc_i & ~clear_i & ~load_i;

  assign carry_o  = do_inc & at_max;
  assign borrow_o = do_dec & at_zero;

  // Ripple BCD increment/decrement of the current digits. The wrap and
  // saturate cases at MAX_COUNT/0 are handled in the next-state logic, so
  // these only ever see values strictly inside the legal range.
  always_comb begin
    logic c;
    logic b;
    logic [3:0] d;
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first; a path that skips an assignment would infer a latch.
    inc_digits = digits_q;
    dec_digits = digits_q;
    c          = 1'b1;
    b          = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = digits_q[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          inc_digits[4*i +: 4] = 4'd0;
        end else begin
          inc_digits[4*i +: 4] = d + 4'd1;
          c                    = 1'b0;
        end
      end
      if (b) begin
        if (d == 4'd0) begin
          dec_digits[4*i +: 4] = 4'd9;
        end else begin
          dec_digits[4*i +: 4] = d - 4'd1;
          b                    = 1'b0;
        end
      end
    end
  end

  // Load validation: every digit must be a decimal digit and the decoded
  // value must not exceed MAX_COUNT. A 32-bit accumulator covers 6 digits.
  always_comb begin
    load_val       = '0;
    load_digits_ok = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (load_digits_i[4*i +: 4] > 4'd9) load_digits_ok = 1'b0;
      load_val = load_val * 32'd10 + {28'd0, load_digits_i[4*i +: 4]};
    end
    load_ok = load_digits_ok && (load_val <= 32'(MAX_COUNT));
  end

  // Next-state selection: clear > load > single-direction count.
  always_comb begin
    digits_d   = digits_q;
    count_d    = count_q;
    load_err_d = 1'b0;
    if (clear_i) begin
      digits_d = RESET_BCD;
      count_d  = RESET_BIN;
    end else if (load_i) begin
      if (load_ok) begin
        digits_d = load_digits_i;
        count_d  = load_val[BIN_W-1:0];
      end else begin
        load_err_d = 1'b1;
      end
    end else if (do_inc) begin
      if (at_max) begin
`ifdef BCD_COUNTER_SATURATE_EN
        digits_d = MAX_BCD;
        count_d  = MAX_BIN;
`else
        digits_d = '0;
        count_d  = '0;
`endif
      end else begin
        digits_d = inc_digits;
        count_d  = count_q + ONE_BIN;
      end
    end else if (do_dec) begin
      if (at_zero) begin
`ifdef BCD_COUNTER_SATURATE_EN
        digits_d = '0;
        count_d  = '0;
`else
        digits_d = MAX_BCD;
        count_d  = MAX_BIN;
`endif
      end else begin
        digits_d = dec_digits;
        count_d  = count_q - ONE_BIN;
      end
    end
  end

  // NOTE: every state flop is reset asynchronously so that an asserted rst_ni
  // drops any in-flight count at once; sequential state uses '<=' only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q   <= RESET_BCD;
      count_q    <= RESET_BIN;
      load_err_q <= 1'b0;
    end else begin
      digits_q   <= digits_d;
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  assign digits_o   = digits_q;
  assign count_o    = count_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Directed bench for bcd_updown_counter. Four instances:
//   u_a : 2 digits, MAX 59, reset 30  (reset/clear, up wrap, loads, priority)
//   u_b : 2 digits, MAX 23, reset 0   (down wrap)
//   u_s : 2 digits, MAX 59 (seconds) chained by carry into
//   u_h : 2 digits, MAX 23 (hours)
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // u_a
  logic       a_clear, a_load, a_inc, a_dec;
  logic [7:0] a_ld;
  logic [7:0] a_digits;
  logic [5:0] a_count;
  logic       a_carry, a_borrow, a_err;

  // u_b
  logic       b_clear, b_load, b_inc, b_dec;
  logic [7:0] b_ld;
  logic [7:0] b_digits;
  logic [4:0] b_count;
  logic       b_carry, b_borrow, b_err;

  // chained pair
  logic       s_load, s_inc, h_load, zero;
  logic [7:0] s_ld, h_ld;
  logic [7:0] s_digits, h_digits;
  logic [5:0] s_count;
  logic [4:0] h_count;
  logic       s_carry, s_borrow, s_err;
  logic       h_carry, h_borrow, h_err;

  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(59), .RESET_VALUE(30)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear), .load_i(a_load),
    .load_digits_i(a_ld), .inc_i(a_inc), .dec_i(a_dec),
    .digits_o(a_digits), .count_o(a_count), .carry_o(a_carry),
    .borrow_o(a_borrow), .load_err_o(a_err)
  );

  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(23), .RESET_VALUE(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .load_i(b_load),
    .load_digits_i(b_ld), .inc_i(b_inc), .dec_i(b_dec),
    .digits_o(b_digits), .count_o(b_count), .carry_o(b_carry),
    .borrow_o(b_borrow), .load_err_o(b_err)
  );

  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(59), .RESET_VALUE(0)) u_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(zero), .load_i(s_load),
    .load_digits_i(s_ld), .inc_i(s_inc), .dec_i(zero),
    .digits_o(s_digits), .count_o(s_count), .carry_o(s_carry),
    .borrow_o(s_borrow), .load_err_o(s_err)
  );

  bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(23), .RESET_VALUE(0)) u_h (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(zero), .load_i(h_load),
    .load_digits_i(h_ld), .inc_i(s_carry), .dec_i(zero),
    .digits_o(h_digits), .count_o(h_count), .carry_o(h_carry),
    .borrow_o(h_borrow), .load_err_o(h_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  initial begin
    int v;
    rst_n   = 1'b1;
    a_clear = 1'b0; a_load = 1'b0; a_inc = 1'b0; a_dec = 1'b0; a_ld = 8'h00;
    b_clear = 1'b0; b_load = 1'b0; b_inc = 1'b0; b_dec = 1'b0; b_ld = 8'h00;
    s_load  = 1'b0; s_inc  = 1'b0; h_load = 1'b0; zero = 1'b0;
    s_ld    = 8'h00; h_ld  = 8'h00;

    // ---- power-on reset ------------------------------------------------
    #2 rst_n = 1'b0;
    #1;
    check("rst_digits", 32'(a_digits), 32'h30);
    check("rst_count",  32'(a_count),  32'd30);
    check("rst_err",    32'(a_err),    32'd0);
    check("rst_b",      32'(b_digits), 32'h00);
    #9 rst_n = 1'b1;   // released between edges
    tick();

    // ---- reset mid-count at 45 -----------------------------------------
    a_load = 1'b1; a_ld = 8'h43; tick(); a_load = 1'b0;
    a_inc = 1'b1; tick(); tick(); a_inc = 1'b0;
    check("mid_pre_digits", 32'(a_digits), 32'h45);
    check("mid_pre_count",  32'(a_count),  32'd45);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_digits", 32'(a_digits), 32'h30);
    check("mid_rst_count",  32'(a_count),  32'd30);
    #1 rst_n = 1'b1;
    tick();

    // ---- count to 33 then clear ----------------------------------------
    a_inc = 1'b1; tick(); tick(); tick(); a_inc = 1'b0;
    check("cnt33_digits", 32'(a_digits), 32'h33);
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    check("clear_digits", 32'(a_digits), 32'h30);
    check("clear_count",  32'(a_count),  32'd30);
    check("clear_err",    32'(a_err),    32'd0);

    // ---- ones-to-tens ripple: 09 -> 10 ---------------------------------
    a_load = 1'b1; a_ld = 8'h09; tick(); a_load = 1'b0;
    a_inc = 1'b1; tick(); a_inc = 1'b0;
    check("ripple_digits", 32'(a_digits), 32'h10);
    check("ripple_count",  32'(a_count),  32'd10);

    // ---- up wrap at 59 -------------------------------------------------
    a_load = 1'b1; a_ld = 8'h58; tick(); a_load = 1'b0;
    a_inc = 1'b1; #1;
    check("up58_carry", 32'(a_carry), 32'd0);
    tick();
    check("up59_digits", 32'(a_digits), 32'h59);
    check("up59_count",  32'(a_count),  32'd59);
    check("up59_carry",  32'(a_carry),  32'd1);
    tick();
    check("up2_digits", 32'(a_digits), SAT ? 32'h59 : 32'h00);
    check("up2_count",  32'(a_count),  SAT ? 32'd59 : 32'd0);
    check("up2_carry",  32'(a_carry),  SAT ? 32'd1  : 32'd0);
    tick();
    check("up3_digits", 32'(a_digits), SAT ? 32'h59 : 32'h01);
    check("up3_count",  32'(a_count),  SAT ? 32'd59 : 32'd1);
    a_inc = 1'b0;

    // ---- invalid / valid loads -----------------------------------------
    a_load = 1'b1; a_ld = 8'h21; tick();
    check("ld21_digits", 32'(a_digits), 32'h21);
    a_ld = 8'h5A; tick(); a_load = 1'b0;
    check("ld5A_held", 32'(a_digits), 32'h21);
    check("ld5A_cnt",  32'(a_count),  32'd21);
    check("ld5A_err",  32'(a_err),    32'd1);
    tick();
    check("err_pulse_end", 32'(a_err), 32'd0);
    a_load = 1'b1; a_ld = 8'h60; tick(); a_load = 1'b0;
    check("ld60_held", 32'(a_digits), 32'h21);
    check("ld60_err",  32'(a_err),    32'd1);
    a_load = 1'b1; a_ld = 8'h59; tick(); a_load = 1'b0;
    check("ld59_digits", 32'(a_digits), 32'h59);
    check("ld59_count",  32'(a_count),  32'd59);
    check("ld59_err",    32'(a_err),    32'd0);

    // ---- simultaneous events -------------------------------------------
    a_inc = 1'b1; a_dec = 1'b1; #1;
    check("both_carry",  32'(a_carry),  32'd0);
    check("both_borrow", 32'(a_borrow), 32'd0);
    tick();
    check("both_hold", 32'(a_digits), 32'h59);
    a_dec = 1'b0; a_load = 1'b1; a_ld = 8'h12; #1;
    check("ld_inc_carry", 32'(a_carry), 32'd0);
    a_clear = 1'b1; tick();
    a_clear = 1'b0; a_load = 1'b0; a_inc = 1'b0;
    check("prio_digits", 32'(a_digits), 32'h30);
    check("prio_count",  32'(a_count),  32'd30);

    // ---- down wrap, MAX 23 ---------------------------------------------
    b_load = 1'b1; b_ld = 8'h10; tick(); b_load = 1'b0;
    check("b_ld10", 32'(b_digits), 32'h10);
    v = 10;
    b_dec = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("b_borrow", 32'(b_borrow), (v == 0) ? 32'd1 : 32'd0);
      tick();
      v = (v == 0) ? (SAT ? 0 : 23) : v - 1;
      check("b_digits", 32'(b_digits), 32'(bcd2(v)));
      check("b_count",  32'(b_count),  32'(v));
    end
    // Return to 0 and check that inc+dec suppresses the borrow.
    b_dec = 1'b0; b_load = 1'b1; b_ld = 8'h00; tick(); b_load = 1'b0;
    b_inc = 1'b1; b_dec = 1'b1; #1;
    check("b_both_borrow", 32'(b_borrow), 32'd0);
    tick();
    check("b_both_hold", 32'(b_digits), 32'h00);
    b_inc = 1'b0; b_dec = 1'b0;

    // ---- chained 23:59 + 1 ---------------------------------------------
    s_load = 1'b1; s_ld = 8'h59; h_load = 1'b1; h_ld = 8'h23; tick();
    s_load = 1'b0; h_load = 1'b0;
    check("chain_pre_s", 32'(s_digits), 32'h59);
    check("chain_pre_h", 32'(h_digits), 32'h23);
    s_inc = 1'b1; #1;
    check("chain_carry",  32'(s_carry), 32'd1);
    check("chain_hcarry", 32'(h_carry), 32'd1);
    tick(); s_inc = 1'b0;
    check("chain_s", 32'(s_digits), SAT ? 32'h59 : 32'h00);
    check("chain_h", 32'(h_digits), SAT ? 32'h23 : 32'h00);
    check("chain_hc", 32'(h_count), SAT ? 32'd23 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
